// File: rtl/load_store_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_monitor_if
// Purpose  : Bundles the checked pulse line and the monitor's result signals.
//            The master side owns the pulse source; the slave side is the
//            passive monitor that reports lock, pulse strobes and errors.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_monitor_if;
  logic        sig;
  logic        locked;
  logic        pulse;
  logic [15:0] pulse_cnt;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output sig,
    input  locked, pulse, pulse_cnt, err, err_code
  );

  modport slave (
    input  sig,
    output locked, pulse, pulse_cnt, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/load_store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : load_store_monitor
// Purpose  : Passive checker for the load/store volume oscillator pulse train.
//            A legal train is 2 cycles high followed by exactly 2N cycles low.
//            Locks after one verified period, counts valid pulses and latches
//            the first violation with a cause code until reset.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_monitor #(
  parameter int N     = 7500,
  parameter int CBITS = 14
) (
  input  wire                 clk,
  input  wire                 rst,
  load_store_monitor_if.slave bus
);

  // Required low-gap length and the fixed high-run length.
  localparam logic [CBITS-1:0] C_GAP  = CBITS'(2 * N);
  localparam logic [CBITS-1:0] C_HIGH = CBITS'(2);
  localparam logic [CBITS-1:0] C_ONE  = CBITS'(1);

  localparam logic [1:0] C_ERR_NONE  = 2'd0;
  localparam logic [1:0] C_ERR_SHORT = 2'd1;
  localparam logic [1:0] C_ERR_LONG  = 2'd2;
  localparam logic [1:0] C_ERR_GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CBITS-1:0] r_run;
  logic             r_sig_q;
  logic             r_locked;
  logic             r_pulse;
  logic [15:0]      r_pulse_cnt;
  logic             r_err;
  logic [1:0]       r_err_code;

  // Single-process checker FSM: tracks run lengths and updates every output
  // on the same edge that samples the deciding sig value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_run       <= '0;
      // Treat a line already high at reset as "not a rise".
      r_sig_q     <= 1'b1;
      r_locked    <= 1'b0;
      r_pulse     <= 1'b0;
      r_pulse_cnt <= 16'd0;
      r_err       <= 1'b0;
      r_err_code  <= C_ERR_NONE;
    end else begin
      r_sig_q <= bus.sig;
      r_pulse <= 1'b0;
      case (r_state)
        S_SYNC: begin
          if (bus.sig && !r_sig_q) begin
            r_state <= S_HIGH;
            r_run   <= C_ONE;
          end
        end

        S_HIGH: begin
          if (bus.sig) begin
            if (r_run < C_HIGH) begin
              r_run <= r_run + C_ONE;
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= C_ERR_LONG;
              r_locked   <= 1'b0;
            end
          end else begin
            if (r_run == C_HIGH) begin
              r_state <= S_LOW;
              r_run   <= C_ONE;
              r_pulse <= 1'b1;
              if (r_pulse_cnt != 16'hFFFF) begin
                r_pulse_cnt <= r_pulse_cnt + 16'd1;
              end
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= C_ERR_SHORT;
              r_locked   <= 1'b0;
            end
          end
        end

        S_LOW: begin
          if (!bus.sig) begin
            if (r_run < C_GAP) begin
              r_run <= r_run + C_ONE;
            end else begin
              // Gap ran past 2N without a rise.
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= C_ERR_GAP;
              r_locked   <= 1'b0;
            end
          end else begin
            if (r_run == C_GAP) begin
              r_state  <= S_HIGH;
              r_run    <= C_ONE;
              r_locked <= 1'b1;
            end else begin
              // Rise arrived before the gap reached 2N.
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= C_ERR_GAP;
              r_locked   <= 1'b0;
            end
          end
        end

        S_ERR: begin
          // Absorbing: hold the error, keep the count frozen.
          r_locked <= 1'b0;
        end

        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  assign bus.locked    = r_locked;
  assign bus.pulse     = r_pulse;
  assign bus.pulse_cnt = r_pulse_cnt;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_load_store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_monitor
// Purpose  : Self-checking bench for load_store_monitor with N=4. The
//            reference model predicts outputs from the position of each
//            sample within the ideal period anchored at the first rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_monitor;

  localparam int N = 4;
  localparam int P = 2 * N + 2;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  load_store_monitor_if bus ();

  load_store_monitor #(.N(N), .CBITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model state.
  bit          m_found;
  int          m_r0;
  int          m_t;
  bit          m_prev;
  bit          m_err;
  logic [1:0]  m_code;
  logic [15:0] m_cnt;
  bit          m_locked;
  bit          m_pulse;

  task automatic model_update(input logic s, input logic r);
    int off;
    bit exp_bit;
    if (r) begin
      m_found = 0; m_r0 = 0; m_t = 0; m_prev = 1;
      m_err = 0; m_code = 2'd0; m_cnt = 16'd0; m_locked = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (!m_found) begin
        if (s && !m_prev) begin
          m_found = 1;
          m_r0    = m_t;
        end
      end else if (!m_err) begin
        off     = (m_t - m_r0) % P;
        exp_bit = (off < 2);
        if (s != exp_bit) begin
          m_err    = 1;
          m_locked = 0;
          if (off == 1)      m_code = 2'd1;
          else if (off == 2) m_code = 2'd2;
          else               m_code = 2'd3;
        end else begin
          if (off == 2) begin
            m_pulse = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
          if (off == 0) m_locked = 1;
        end
      end
      m_prev = s;
      m_t    = m_t + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("locked",    {15'd0, bus.locked},   {15'd0, m_locked});
    chk("pulse",     {15'd0, bus.pulse},    {15'd0, m_pulse});
    chk("pulse_cnt", bus.pulse_cnt,         m_cnt);
    chk("err",       {15'd0, bus.err},      {15'd0, m_err});
    chk("err_code",  {14'd0, bus.err_code}, {14'd0, m_code});
  endtask

  task automatic step(input logic s, input logic r);
    bus.sig = s;
    rst     = r;
    @(posedge clk);
    model_update(s, r);
    #1;
    check_all();
  endtask

  task automatic run(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0);
  endtask

  task automatic period();
    run(1'b1, 2);
    run(1'b0, 2 * N);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    int ph;
    logic b;
    logic r;
    bus.sig = 1'b0;
    rst     = 1'b1;

    // Reset state.
    do_reset();
    chk("reset_cnt", bus.pulse_cnt, 16'd0);

    // Legal train of 5 periods.
    run(1'b0, 3);
    repeat (5) period();
    chk("legal_cnt5", bus.pulse_cnt, 16'd5);
    chk("legal_lock", {15'd0, bus.locked}, 16'd1);
    chk("legal_noerr", {15'd0, bus.err}, 16'd0);

    // Sig high through reset and beyond.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    run(1'b1, 3);
    run(1'b0, 3);
    repeat (3) period();
    chk("hireset_cnt3", bus.pulse_cnt, 16'd3);

    // Long high run.
    do_reset();
    run(1'b0, 2);
    period();
    run(1'b1, 3);
    chk("longhi_code", {14'd0, bus.err_code}, 16'd2);
    chk("longhi_cnt",  bus.pulse_cnt, 16'd1);
    run(1'b0, 4);

    // Short low gap.
    do_reset();
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 2 * N - 1);
    step(1'b1, 1'b0);
    chk("shortgap_code", {14'd0, bus.err_code}, 16'd3);

    // Long low gap.
    do_reset();
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 2 * N + 1);
    chk("longgap_code", {14'd0, bus.err_code}, 16'd3);

    // High run of one cycle.
    do_reset();
    run(1'b0, 2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("hi1_code", {14'd0, bus.err_code}, 16'd1);
    run(1'b0, 3);

    // Reset in the middle of a gap after lock, then relock.
    do_reset();
    run(1'b0, 1);
    repeat (2) period();
    run(1'b1, 2);
    run(1'b0, 3);
    step(1'b0, 1'b1);
    chk("midrst_cnt", bus.pulse_cnt, 16'd0);
    run(1'b0, 2);
    period();
    step(1'b1, 1'b0);
    chk("relock", {15'd0, bus.locked}, 16'd1);
    chk("relock_cnt", bus.pulse_cnt, 16'd1);

    // Randomized: mostly-legal trains with occasional bit flips and resets.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run(1'b0, $urandom_range(0, 5));
      ph = 0;
      for (int c = 0; c < 60; c++) begin
        b = (ph < 2);
        if ($urandom_range(0, 79) == 0) b = ~b;
        r = ($urandom_range(0, 149) == 0);
        step(b, r);
        ph = (ph + 1) % P;
      end
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_monitor.md
# load_store_monitor

Passive checker that sits on the `sig` line of a load/store volume oscillator and verifies its pulse train. A correct source drives `sig` high for exactly 2 consecutive cycles, then low for exactly 2N cycles, repeating with a period of 2N+2. The block locks onto that pattern, counts valid pulses, and raises a sticky error with a cause code on the first violation. It is the consumer-side companion of the oscillator and is intended for formal and simulation benches.

## Interface

Parameters:
- `N`, default 7500: oscillator full-scale volume; the required low gap is 2N cycles.
- `CBITS`, default 14: run-counter width; must satisfy 2N < 2^CBITS.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `sig`, input, 1: pulse train under check.
- `locked`, output, 1: at least one full rise-to-rise period has been verified and no error has occurred.
- `pulse`, output, 1: one-cycle strobe marking each completed valid high pulse.
- `pulse_cnt`, output, 16: count of valid high pulses, saturating at 16'hFFFF.
- `err`, output, 1: sticky violation flag.
- `err_code`, output, 2: cause of the violation, as follows:
  - 0: none.
  - 1: high run too short.
  - 2: high run too long.
  - 3: low gap not equal to 2N.

## Operation

- **Registers:**
  - `sig_q` holds the previous sampled `sig`; it resets to 1, so a `sig` already high at reset is not treated as a rise.
  - `run[CBITS-1:0]` is the length of the current run.
  - `state` is one of SYNC, HIGH, LOW, ERR.
- **SYNC**
  - Entered by reset.
  - On `sig`=1 with `sig_q`=0 (rising edge): go to HIGH and set `run`=1.
  - Otherwise stay in SYNC. No errors are checked in SYNC.
- **HIGH**
  - `sig`=1 with `run`<2: `run`++.
  - `sig`=1 with `run`==2: go to ERR with code 2.
  - `sig`=0 with `run`==2: go to LOW, set `run`=1, pulse `pulse`=1, and increment `pulse_cnt` (saturating).
  - `sig`=0 with `run`<2: go to ERR with code 1.
- **LOW**
  - `sig`=0 with `run`<2N: `run`++.
  - `sig`=0 with `run`==2N: go to ERR with code 3 (gap too long).
  - `sig`=1 with `run`==2N: go to HIGH, set `run`=1, set `locked`=1.
  - `sig`=1 with `run`<2N: go to ERR with code 3 (gap too short).
- **ERR**
  - Absorbing; only `rst` exits.
  - `err`=1 and `err_code` are held; `locked`=0; `pulse`=0; `pulse_cnt` is frozen.
- **Arithmetic:** `run` never exceeds 2N, because every overflow path goes to ERR first. `pulse_cnt` holds at all-ones once saturated.
- **Reset mid-operation:** on the next edge, all outputs are cleared, `run`=0, `sig_q`=1, and `state`=SYNC. Any pulse in flight is ignored until a fresh rising edge.

## Timing

- All outputs are registered and update at the same posedge that samples the deciding `sig` value.
- **Reset values:**
  - `locked`=0, `pulse`=0, `pulse_cnt`=0, `err`=0, `err_code`=0.
  - `state`=SYNC, `run`=0, `sig_q`=1.
- `pulse` is high for exactly one cycle: the cycle after the edge that samples the first low following a valid 2-cycle high.
- `locked` rises at the edge that samples the second rising edge, i.e. the rise that closes a 2N-cycle gap. That is 2N+2 cycles after the first sampled rise.
- `err` and `err_code` become valid at the edge that samples the offending `sig` value, with zero extra latency.
- `rst` has priority over every transition, including entry into ERR on the same edge.

## Test plan

All scenarios use N=4, so the required pattern is 2 cycles high, 8 cycles low.

- **Legal train:** reset, then drive a legal train of 5 periods. Required:
  - `locked`=1 from the 2nd rise onward.
  - Exactly 5 `pulse` strobes.
  - `pulse_cnt`=5.
  - `err`=0.
- **`sig` high through reset:** hold `sig`=1 during and 3 cycles after reset, then drive the legal train. Required: the initial high is ignored, and the first counted pulse is the first true rise.
- **Long high run:** a legal period, then `sig` high for 3 cycles. Required:
  - `err`=1 and `err_code`=2 at the edge sampling the 3rd high.
  - `locked`=0.
  - `pulse_cnt` frozen at 1.
- **Short low gap:** a high of 2 cycles, then low for 7 cycles, then a rise. Required: `err_code`=3 at the rise. Also run the long case (low for 9 cycles), which requires `err_code`=3 at the edge sampling the 9th low.
- **High run of 1:** a single-cycle high pulse. Required: `err_code`=1 at the falling sample, and `pulse` is never asserted.
- **Reset mid-operation:** reset in the middle of a low gap after `locked`=1. Required:
  - All outputs are 0 on the next edge.
  - Relock occurs after one full new period.
  - `pulse_cnt` restarts from 0.
